uart_rx: RTL and testbench

UART receiver that turns the serial line into bytes for the register command FSM, which sits directly downstream. It synchronises the asynchronous RX pin, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each good frame produces a one-cycle `rx_done_o` pulse with the byte on `data_o`, matching the `rx_done_i`/`data_i` contract of the command FSM. It has no flow control; every accepted byte is presented exactly once.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx. The receiver owns the byte outputs and
// the debug state; the line and the downstream consumer sit on the slave side.
//
// Handshake: rx_done_o is a one-cycle valid pulse with data_o; there is no
// ready. The consumer must take the byte in that cycle. data_o holds until the
// next good frame. frame_err_o is a one-cycle pulse that never coincides with
// rx_done_o.
interface uart_rx_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       rx_done_o;
  logic       frame_err_o;
  logic       busy_o;
  logic [2:0] state_dbg;

  modport master (
    input  rx_i,
    output data_o,
    output rx_done_o,
    output frame_err_o,
    output busy_o,
    output state_dbg
  );

  modport slave (
    output rx_i,
    input  data_o,
    input  rx_done_o,
    input  frame_err_o,
    input  busy_o,
    input  state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling. It synchronises the
// asynchronous line, validates the start bit at half a bit, and checks the
// stop bit. A low stop bit parks the FSM until the line returns high, so a
// break is not decoded as a stream of 0x00 bytes.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic      clk,
  input  logic      rst_n,   // active-high asynchronous reset
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  // Too few clocks per bit leaves no room for mid-bit sampling.
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t           state, state_n;
  logic             sync1, rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_q, shift_n;
  logic [7:0]       data_q, data_n;
  logic             done_q, done_n;
  logic             ferr_q, ferr_n;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_i;
      rx_s  <= sync1;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      done_q  <= done_n;
      ferr_q  <= ferr_n;
    end
  end

  // Next-state and datapath decisions; pulses default low every cycle.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_q;
    data_n    = data_q;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          clk_cnt_n = '0;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          if (!rx_s) begin
            clk_cnt_n = '0;
            bit_idx_n = '0;
            state_n   = S_DATA;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_n = S_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          shift_n   = {rx_s, shift_q[7:1]};
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            data_n  = shift_q;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_WAIT_HIGH;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.data_o      = data_q;
  assign bus.rx_done_o   = done_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit. Stimulus tasks push the expected
// pulse {is_error, data_o} into exp_q; a negedge monitor pops and compares
// whenever rx_done_o or frame_err_o is seen.
module tb_uart_rx;
  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_cyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] prev_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Driver tasks: all start and end at posedge+1.
  task automatic drive_bit(input logic b);
    bus.rx_i = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
    prev_byte = d;
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, prev_byte});
  endtask

  task automatic idle(input int n);
    bus.rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] got;
    logic [8:0] e;
    cyc++;
    if (bus.rx_done_o && bus.frame_err_o) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap: rx_done_o and frame_err_o both high at cycle %0d", cyc);
    end
    if (bus.rx_done_o || bus.frame_err_o) begin
      got = {bus.frame_err_o, bus.data_o};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got 0x%0h expected no pulse", got);
      end else begin
        e = exp_q.pop_front();
        check("rx_pulse", {23'd0, got}, {23'd0, e});
      end
      if (bus.rx_done_o) done_cyc.push_back(cyc);
    end
  end

  initial begin
    int n;
    bus.rx_i = 1'b1;
    rst_n    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // Reset state
    check("reset_data", bus.data_o, 8'h00);
    check("reset_done", bus.rx_done_o, 1'b0);
    check("reset_ferr", bus.frame_err_o, 1'b0);
    check("reset_busy", bus.busy_o, 1'b0);
    rst_n = 1'b0;
    idle(10);

    // Single byte
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(5);
    wait_drain("a5_drain");

    // Back-to-back, zero gap
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h01);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h01, 1'b1);
    idle(5);
    wait_drain("b2b_drain");
    n = done_cyc.size();
    check("b2b_count", n, 4);
    if (n >= 3) begin
      check_range("b2b_gap1", done_cyc[n-2] - done_cyc[n-3], 98, 102);
      check_range("b2b_gap2", done_cyc[n-1] - done_cyc[n-2], 98, 102);
    end
    idle(20);

    // Start glitch
    bus.rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
    end
    check("glitch_busy_clear", bus.busy_o, 1'b0);
    idle(20);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(5);
    wait_drain("3c_drain");

    // Framing error, then line held low
    expect_err();
    send_frame(8'h55, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    wait_drain("ferr_drain");
    check("ferr_wait_high", bus.state_dbg, 3'd4);
    check("ferr_data_kept", bus.data_o, 8'h3C);
    idle(20);
    expect_byte(8'h12);
    send_frame(8'h12, 1'b1);
    idle(5);
    wait_drain("12_drain");

    // Reset during bit 4 of 0xC3
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(n[0] ? 1'b1 : 1'b1 & (8'hC3 >> i));
    bus.rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midframe_busy", bus.busy_o, 1'b1);
    rst_n = 1'b1;
    #1;
    check("midrst_data", bus.data_o, 8'h00);
    check("midrst_done", bus.rx_done_o, 1'b0);
    check("midrst_ferr", bus.frame_err_o, 1'b0);
    check("midrst_busy", bus.busy_o, 1'b0);
    prev_byte = 8'h00;
    bus.rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(20);
    expect_byte(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(5);
    wait_drain("7e_drain");

    // Command stream: write, address 0, data 1
    expect_byte(8'h01);
    expect_byte(8'h00);
    expect_byte(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h01, 1'b1);
    idle(5);
    wait_drain("cmd_drain");
    check("cmd_last_data", bus.data_o, 8'h01);

    idle(20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
